// File: rtl/deq_pkg.sv
// Shared sizing constants for the dequantizer bit extraction path.
package deq_pkg;

  localparam int unsigned WWIDTH  = 32;
  localparam int unsigned MAXCODE = 16;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned BUF_W   = 2 * WWIDTH;
  localparam int unsigned FILL_W  = $clog2(BUF_W + 1);

  // Width of a counter that must represent 0..2*w inclusive.
  function automatic int unsigned fill_width(input int unsigned w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/bit_extractor_if.sv
// Packed-word input stream and extracted-field output stream of the bit extractor.
interface bit_extractor_if
  import deq_pkg::*;
#(
  parameter int unsigned W = WWIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_word;
  logic [LEN_W-1:0] code_len;
  logic [LEN_W-1:0] shift;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     ExtractedBits;

  modport master (
    output in_valid, in_word, code_len, shift, flush, out_ready,
    input  in_ready, out_valid, ExtractedBits
  );

  modport slave (
    input  in_valid, in_word, code_len, shift, flush, out_ready,
    output in_ready, out_valid, ExtractedBits
  );

endinterface

// File: rtl/bit_extractor_field_aligner.sv
// Masks the low code_len bits of the buffer, zero-extends and shifts them into place.
module field_aligner #(
  parameter int unsigned W     = deq_pkg::WWIDTH,
  parameter int unsigned LEN_W = deq_pkg::LEN_W
) (
  input  logic [W-1:0]     low_bits,
  input  logic [LEN_W-1:0] code_len,
  input  logic [LEN_W-1:0] shift,
  output logic [W-1:0]     field_c
);

  logic [W-1:0] mask;

  // Bits shifted past the MSB fall off, which gives the silent truncation.
  always_comb begin
    mask    = ~({W{1'b1}} << code_len);
    field_c = (low_bits & mask) << shift;
  end

endmodule

// File: rtl/bit_extractor.sv
// Unpacks variable-width code fields from a stream of packed words, LSB oldest.
module bit_extractor #(
  parameter int unsigned WWIDTH  = deq_pkg::WWIDTH,
  parameter int unsigned MAXCODE = deq_pkg::MAXCODE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WWIDTH-1:0]          in_word,
  input  logic [deq_pkg::LEN_W-1:0]  code_len,
  input  logic [deq_pkg::LEN_W-1:0]  shift,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WWIDTH-1:0]          ExtractedBits
);

  localparam int unsigned LEN_W  = deq_pkg::LEN_W;
  localparam int unsigned BUF_W  = 2 * WWIDTH;
  localparam int unsigned FILL_W = deq_pkg::fill_width(WWIDTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAXCODE);

  logic [BUF_W-1:0]  buf_q, buf_d, buf_post;
  logic [FILL_W-1:0] fill_q, fill_d, fill_post;
  logic              out_valid_q, out_valid_d;
  logic [WWIDTH-1:0] data_q, data_d;
  logic [WWIDTH-1:0] field_c;
  logic              len_ok, accept, extract;

  field_aligner #(
    .W     (WWIDTH),
    .LEN_W (LEN_W)
  ) u_aligner (
    .low_bits (buf_q[WWIDTH-1:0]),
    .code_len (code_len),
    .shift    (shift),
    .field_c  (field_c)
  );

  // Extraction consumes first; an accepted word lands above the post-extraction fill.
  always_comb begin
    len_ok      = (code_len != '0) && (code_len <= MAX_LEN);
    in_ready    = (fill_q <= FILL_W'(WWIDTH)) && !flush;
    accept      = in_valid && in_ready;
    extract     = !flush && len_ok && (fill_q >= FILL_W'(code_len)) &&
                  (!out_valid_q || out_ready);
    buf_post    = extract ? (buf_q >> code_len) : buf_q;
    fill_post   = extract ? (fill_q - FILL_W'(code_len)) : fill_q;
    buf_d       = buf_post;
    fill_d      = fill_post;
    out_valid_d = out_valid_q;
    data_d      = data_q;

    if (accept) begin
      buf_d  = buf_post | (BUF_W'(in_word) << fill_post);
      fill_d = fill_post + FILL_W'(WWIDTH);
    end

    if (extract) begin
      data_d      = field_c;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Buffer is zeroed too so bits above fill stay clear for the OR-append.
    if (flush) begin
      buf_d       = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign ExtractedBits = data_q;

endmodule

// File: tb/tb_bit_extractor.sv
// Scoreboard bench: a bit-queue reference model predicts every extracted field.
module tb_bit_extractor;

  logic clk = 1'b0;
  logic rst_n;

  bit_extractor_if #(.W(32)) bif ();

  bit_extractor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (bif.in_valid),
    .in_ready      (bif.in_ready),
    .in_word       (bif.in_word),
    .code_len      (bif.code_len),
    .shift         (bif.shift),
    .flush         (bif.flush),
    .out_valid     (bif.out_valid),
    .out_ready     (bif.out_ready),
    .ExtractedBits (bif.ExtractedBits)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  bit          bitq[$];
  logic [31:0] exp_q[$];
  int          cur_len = 0;
  int          cur_sh  = 0;

  logic rand_ready   = 1'b0;
  logic forced_ready = 1'b1;
  logic rnd_bit      = 1'b0;

  assign bif.out_ready = rand_ready ? rnd_bit : forced_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stream is a FIFO of bits; each field pops code_len of them.
  function automatic void model_extract();
    logic [31:0] f;
    while (cur_len >= 1 && cur_len <= 16 && bitq.size() >= cur_len) begin
      f = '0;
      for (int i = 0; i < cur_len; i++) f[i] = bitq.pop_front();
      exp_q.push_back(f << cur_sh);
    end
  endfunction

  task automatic set_len(input int l, input int s);
    bif.code_len = 5'(l);
    bif.shift    = 5'(s);
    cur_len      = l;
    cur_sh       = s;
    model_extract();
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_word  = w;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bif.in_ready;
      @(posedge clk);
      #1;
    end
    bif.in_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
    if (ok) begin
      for (int b = 0; b < 32; b++) bitq.push_back(w[b]);
      model_extract();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    bif.flush    = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_word  = $urandom;
    @(negedge clk);
    check("flush_in_ready", 32'(bif.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bif.flush    = 1'b0;
    bif.in_valid = 1'b0;
    bitq.delete();
    exp_q.delete();
    check("flush_fill", 32'(dut.fill_q), 32'd0);
    check("flush_out_valid", 32'(bif.out_valid), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: every downstream handshake pops one prediction.
  initial forever begin
    @(negedge clk);
    if (rst_n && bif.out_valid && bif.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h expected none at %0t", bif.ExtractedBits, $time);
      end else begin
        check("extracted", bif.ExtractedBits, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_word  = '0;
    bif.code_len = '0;
    bif.shift    = '0;
    bif.flush    = 1'b0;
    #23;
    check("reset_out_valid", 32'(bif.out_valid), 32'd0);
    check("reset_data", bif.ExtractedBits, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", 32'(bif.in_ready), 32'd1);

    // Byte fields on consecutive cycles with one cycle of latency.
    set_len(8, 0);
    send_word(32'h44332211);
    @(negedge clk);
    check("latency_valid_low", 32'(bif.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("consecutive_valid", 32'(bif.out_valid), 32'd1);
    end
    @(negedge clk);
    check("stream_end_valid", 32'(bif.out_valid), 32'd0);
    @(posedge clk);
    #1;
    drain();
    do_flush();

    // 12-bit fields straddling a word boundary.
    set_len(12, 0);
    send_word(32'hABCDEF01);
    send_word(32'h00000123);
    drain();
    do_flush();

    // Shifted nibble.
    set_len(4, 20);
    send_word(32'h0000000F);
    drain();
    do_flush();

    // Backpressure: output held, input stalls once fill exceeds a word.
    forced_ready = 1'b0;
    set_len(8, 0);
    send_word(32'h04030201);
    send_word(32'h08070605);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(bif.out_valid), 32'd1);
      check("bp_data_held", bif.ExtractedBits, exp_q[0]);
      check("bp_in_ready_low", 32'(bif.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    forced_ready = 1'b1;
    drain();
    do_flush();

    // Flush with fill=40 and a pending output.
    forced_ready = 1'b0;
    set_len(12, 0);
    send_word(32'h87654321);
    @(posedge clk);
    #1;
    forced_ready = 1'b1;
    @(posedge clk);
    #1;
    forced_ready = 1'b0;
    check("pre_flush_fill8", 32'(dut.fill_q), 32'd8);
    send_word(32'h0FEDCBA9);
    check("pre_flush_fill40", 32'(dut.fill_q), 32'd40);
    check("pre_flush_valid", 32'(bif.out_valid), 32'd1);
    do_flush();
    forced_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_flush_idle", 32'(bif.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Illegal code lengths leave the buffer untouched.
    set_len(0, 0);
    send_word(32'h5A5AC3E1);
    repeat (3) @(posedge clk);
    #1;
    check("len0_fill", 32'(dut.fill_q), 32'd32);
    set_len(17, 0);
    repeat (3) @(posedge clk);
    #1;
    check("len17_fill", 32'(dut.fill_q), 32'd32);
    check("len17_valid", 32'(bif.out_valid), 32'd0);
    set_len(8, 0);
    drain();
    do_flush();

    // Asynchronous reset mid-stream.
    forced_ready = 1'b0;
    set_len(8, 0);
    send_word(32'hDEADBEEF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(bif.out_valid), 32'd0);
    check("midreset_data", bif.ExtractedBits, 32'd0);
    check("midreset_fill", 32'(dut.fill_q), 32'd0);
    bitq.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_in_ready", 32'(bif.in_ready), 32'd1);
    forced_ready = 1'b1;

    // Randomized segments with random backpressure and idle gaps.
    rand_ready = 1'b1;
    for (int seg = 0; seg < 24; seg++) begin
      set_len(int'($urandom_range(1, 16)), int'($urandom_range(0, 31)));
      for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_word($urandom);
      end
      drain();
      do_flush();
    end
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
